// File: rtl/bsg_cache_sbuf_drain.sv
// rtl/bsg_cache_sbuf_drain.sv - store buffer drain: holds one entry, coalesces same-word stores, writes data memory
module bsg_cache_sbuf_drain #(
  parameter int ways_p                = 8,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int data_mem_addr_width_p = 9,
  localparam int lg_ways_lp           = $clog2(ways_p),
  localparam int mask_width_lp        = data_width_p / 8,
  localparam int entry_width_lp       = addr_width_p + data_width_p + mask_width_lp + lg_ways_lp
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [entry_width_lp-1:0]           sbuf_entry_i,
  input  logic                                sbuf_v_i,
  output logic                                sbuf_yumi_o,
  output logic                                dm_v_o,
  output logic [data_mem_addr_width_p-1:0]    dm_addr_o,
  output logic [ways_p*data_width_p-1:0]      dm_data_o,
  output logic [ways_p*mask_width_lp-1:0]     dm_w_mask_o,
  input  logic                                dm_yumi_i,
  input  logic                                bypass_v_i,
  input  logic [addr_width_p-1:0]             bypass_addr_i,
  output logic [data_width_p-1:0]             bypass_data_o,
  output logic [mask_width_lp-1:0]            bypass_mask_o,
  output logic                                idle_o
);

  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_r;

  logic [addr_width_p-1:0]  in_addr;
  logic [data_width_p-1:0]  in_data;
  logic [mask_width_lp-1:0] in_mask;
  logic [lg_ways_lp-1:0]    in_way;
  assign {in_addr, in_data, in_mask, in_way} = sbuf_entry_i;

  logic [addr_width_p-1:0]  addr_r;
  logic [data_width_p-1:0]  data_r;
  logic [mask_width_lp-1:0] mask_r;
  logic [lg_ways_lp-1:0]    way_r;

  logic full, match, coalesce, bypass_hit;
  assign full       = (state_r == FULL);
  assign match      = (in_addr[addr_width_p-1:2] == addr_r[addr_width_p-1:2]) && (in_way == way_r);
  assign bypass_hit = full && (bypass_addr_i[addr_width_p-1:2] == addr_r[addr_width_p-1:2]);

  // A held entry that is not retiring may only absorb a store to the very same word and way.
  assign sbuf_yumi_o = reset_n_i & sbuf_v_i & (~full | dm_yumi_i | match);
  assign coalesce    = full & ~dm_yumi_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r       <= EMPTY;
      bypass_data_o <= '0;
      bypass_mask_o <= '0;
    end else begin
      if (sbuf_yumi_o)
        state_r <= FULL;
      else if (full && dm_yumi_i)
        state_r <= EMPTY;
      if (bypass_v_i) begin
        bypass_data_o <= bypass_hit ? data_r : '0;
        bypass_mask_o <= bypass_hit ? mask_r : '0;
      end
    end
  end

  // Entry payload carries no reset; it is only meaningful while FULL.
  always_ff @(posedge clk_i) begin
    if (sbuf_yumi_o) begin
      if (coalesce) begin
        for (int i = 0; i < mask_width_lp; i++)
          data_r[8*i +: 8] <= in_mask[i] ? in_data[8*i +: 8] : data_r[8*i +: 8];
        mask_r <= mask_r | in_mask;
      end else begin
        addr_r <= in_addr;
        data_r <= in_data;
        mask_r <= in_mask;
        way_r  <= in_way;
      end
    end
  end

  assign dm_v_o    = full;
  assign idle_o    = ~full;
  assign dm_addr_o = addr_r[2 +: data_mem_addr_width_p];
  assign dm_data_o = {ways_p{data_r}};

  always_comb begin
    dm_w_mask_o = '0;
    if (full)
      dm_w_mask_o[way_r*mask_width_lp +: mask_width_lp] = mask_r;
  end

  logic unused_bits;
  assign unused_bits = ^{bypass_addr_i[1:0], addr_r[1:0], in_addr[1:0]};

endmodule

// File: doc/bsg_cache_sbuf_drain.md
# bsg_cache_sbuf_drain

Consumer end of the cache store buffer. Pops entries from the store buffer's valid/yumi output, holds one entry at a time, coalesces back-to-back stores to the same word, and issues a byte-masked write to the way-interleaved data memory when the cache pipeline grants the port. It also answers load-bypass lookups for the entry it holds, because that entry has already left the store buffer.

## Interface
Parameters:
- ways_p, 8, number of ways; lg_ways = clog2(ways_p)
- addr_width_p, 32, byte address width
- data_width_p, 32, word width; data_mask_width = data_width_p/8
- data_mem_addr_width_p, 9, data-memory word-address width
- entry width = addr_width_p + data_width_p + data_mask_width + lg_ways (71 at defaults); layout MSB→LSB {addr, data, mask, way_id}

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_n_i  in  1  synchronous reset, active low
- sbuf_entry_i  in  entry width  head entry of the store buffer
- sbuf_v_i  in  1  head entry valid
- sbuf_yumi_o  out  1  entry consumed this cycle; combinational
- dm_v_o  out  1  write request pending; registered
- dm_addr_o  out  data_mem_addr_width_p  held addr[2 +: data_mem_addr_width_p]
- dm_data_o  out  ways_p*data_width_p  held data replicated into every way lane
- dm_w_mask_o  out  ways_p*data_mask_width  held mask in lane way_id; zero elsewhere, and zero when dm_v_o=0
- dm_yumi_i  in  1  data memory accepts the request this cycle; legal only while dm_v_o=1
- bypass_v_i  in  1  bypass lookup valid
- bypass_addr_i  in  addr_width_p  lookup byte address
- bypass_data_o  out  data_width_p  registered bypass bytes from the held entry
- bypass_mask_o  out  data_mask_width  registered byte-valid mask
- idle_o  out  1  no entry held; equals ~dm_v_o

## Operation
- Two-state FSM: EMPTY and FULL. dm_v_o = (state==FULL).
- A word match means the address bits above bit 1 are equal: sbuf_entry_i.addr[addr_width_p-1:2] == held.addr[addr_width_p-1:2], and way_id is equal.
- EMPTY:
  - sbuf_yumi_o = sbuf_v_i.
  - On yumi, latch the entry and go to FULL.
- FULL with dm_yumi_i=1:
  - The held write retires.
  - If sbuf_v_i=1: sbuf_yumi_o=1, latch the new entry, and stay FULL. A match does not matter in this case; the entry is replaced, not merged.
  - Otherwise go to EMPTY.
- FULL with dm_yumi_i=0:
  - If sbuf_v_i=1 and the entry matches: sbuf_yumi_o=1 and coalesce.
  - Coalesce rule, per byte i: data byte i = new byte if new mask[i] is set, else old byte. Mask = old | new.
  - If there is no match: sbuf_yumi_o=0, nothing changes, and the entry waits.
- Bypass:
  - A hit is FULL & bypass_addr_i[addr_width_p-1:2] == held.addr[addr_width_p-1:2]. Way is ignored.
  - If bypass_v_i=1, the next-cycle values are bypass_mask_o = hit ? held mask : 0 and bypass_data_o = hit ? held data : 0.
  - If bypass_v_i=0, both outputs hold their previous values.
  - The lookup uses pre-edge held state, so an entry coalesced in the same cycle is not yet visible.
- The held address, data, mask and way registers are not reset. Only the state and the bypass outputs are reset.

## Timing
- Reset (reset_n_i=0 at an edge) forces:
  - state to EMPTY, so dm_v_o=0 and idle_o=1 from the next cycle;
  - dm_w_mask_o=0;
  - bypass_data_o=0 and bypass_mask_o=0.
- sbuf_yumi_o is forced to 0 while reset_n_i=0.
- Reset while FULL drops the held entry with no write. Reset wins over dm_yumi_i and over bypass_v_i in the same cycle.
- Latency: an entry popped at edge N gives dm_v_o=1 after edge N. The earliest write is the cycle following edge N.
- Throughput: one entry per cycle when dm_yumi_i is asserted continuously.
- sbuf_yumi_o depends combinationally on sbuf_v_i, sbuf_entry_i, dm_yumi_i and the state. It never depends on bypass inputs.
- Data-memory outputs stay stable while dm_v_o=1 and dm_yumi_i=0. The only exception is a coalesce, which updates dm_data_o and dm_w_mask_o at the edge.
- Bypass latency is 1 cycle: the lookup is presented in cycle N and the result is valid in cycle N+1. This matches the store-buffer bypass, and consumers OR the two masks.

## Test plan
- Reset/single store:
  - Stimulus: reset_n_i=0 for 2 cycles, then entry {addr=0x0000_0104, data=0xAABBCCDD, mask=4'b1111, way=3} with sbuf_v_i for one cycle.
  - Response: sbuf_yumi_o=1 that cycle. Next cycle dm_v_o=1, dm_addr_o=0x041, mask lane 3 = 4'hF, all other lanes 0.
  - Then dm_yumi_i=1 → idle_o=1 the next cycle.
- Coalesce:
  - Stimulus: with FULL holding addr 0x200, data 0x11223344, mask 4'b0011, way 0, dm_yumi_i=0, present addr 0x202, data 0x55660000, mask 4'b1100, way 0.
  - Response: sbuf_yumi_o=1, held data becomes 0x55663344 and mask 4'b1111.
- No-merge stall:
  - Stimulus: FULL holding addr 0x200 way 0, dm_yumi_i=0. Present addr 0x204 (different word), then addr 0x200 way 1.
  - Response: sbuf_yumi_o=0 in both cases and the held entry is unchanged.
- Back-to-back streaming:
  - Stimulus: 4 entries at consecutive words, with dm_yumi_i tied to 1 while dm_v_o=1.
  - Response: 4 writes on 4 consecutive cycles, in order, with no coalescing.
- Bypass:
  - Stimulus: FULL holding addr 0x300, data 0xDEADBEEF, mask 4'b0101; lookup addr 0x303 with bypass_v_i=1.
  - Response: next cycle bypass_data_o=0xDEADBEEF, bypass_mask_o=4'b0101.
  - Then lookup 0x304 → outputs 0 the next cycle. Then bypass_v_i=0 → outputs hold.
- Reset mid-operation:
  - Stimulus: FULL, dm_yumi_i=1 and reset_n_i=0 in the same cycle.
  - Response: next cycle dm_v_o=0, bypass outputs 0, sbuf_yumi_o=0 during reset.
